// File: rtl/ph_ram_responder.sv
// Physical-side RAM slave for the MemoryController: byte-addressed little-endian storage,
// programmable wait states, one-cycle ack. Define PHRAM_BOUNDS_EN to reject out-of-range windows.
module ph_ram_responder #(
    parameter int ADDR_BITS = 16,
    parameter int LATENCY   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] phRamAddress,
    input  logic [31:0] phRamWrite,
    input  logic        phReadReq,
    input  logic        phWriteReq,
    output logic [31:0] phRamRead,
    output logic        phAck,
    output logic        phErr,
    output logic [31:0] debug
);

    // state   | meaning
    // IDLE    | waiting for a read or write request
    // BUSY    | request captured, counting down wait states
    // DONE    | access completed, ack/err high this cycle
    // RELEASE | waiting for the requester to drop its request
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int MEM_BYTES = 2 ** ADDR_BITS;

    state_t               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 is_wr_q, is_wr_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 ack_q, ack_d;
    logic                 oob_q, oob_d;

    logic [7:0]           mem_q [MEM_BYTES];
    logic [31:0]          rd_word;
    logic                 req_any;
    logic                 capture_oob;
    logic                 mem_we;

    assign req_any = phReadReq | phWriteReq;

`ifdef PHRAM_BOUNDS_EN
    localparam int AW1 = ADDR_BITS + 1;

    logic [ADDR_BITS:0] top_sum;
    logic               err_q, err_d;

    // A carry out of addr+3 means the last byte would land beyond the array.
    assign top_sum     = {1'b0, phRamAddress[ADDR_BITS-1:0]} + AW1'(3);
    assign capture_oob = top_sum[ADDR_BITS] | (phRamAddress[31:ADDR_BITS] != '0);
    assign phErr       = err_q;
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^phRamAddress[31:ADDR_BITS];
    assign capture_oob    = 1'b0;
    assign phErr          = 1'b0;
`endif

    // Each byte address wraps on its own, so a window may straddle the top of the array.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            rd_word[8*i +: 8] = mem_q[addr_q + ADDR_BITS'(i)];
        end
    end

    assign mem_we = (state_q == ST_BUSY) && (wait_q == 4'd0) && is_wr_q && !oob_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        oob_d   = oob_q;
        ack_d   = 1'b0;
`ifdef PHRAM_BOUNDS_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    addr_d  = phRamAddress[ADDR_BITS-1:0];
                    wdata_d = phRamWrite;
                    is_wr_d = phWriteReq;
                    oob_d   = capture_oob;
                    wait_d  = 4'(LATENCY);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    ack_d = 1'b1;
`ifdef PHRAM_BOUNDS_EN
                    err_d = oob_q;
`endif
                    if (!is_wr_q && !oob_q) begin
                        rdata_d = rd_word;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = req_any ? ST_RELEASE : ST_IDLE;
            end
            ST_RELEASE: begin
                if (!req_any) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            oob_q   <= oob_d;
        end
    end

`ifdef PHRAM_BOUNDS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Storage is deliberately not reset; reset forces IDLE so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[addr_q + ADDR_BITS'(i)] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign phRamRead = rdata_q;
    assign phAck     = ack_q;
    assign debug     = {24'b0, 2'b0, state_q, wait_q};

endmodule
